// File: rtl/mem_bus_pkg.sv
// Shared encodings and default memory map for the mem_bus_decoder slice.
// Size codes, FSM states and an alignment helper live here so the decoder and its users agree.
package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default map for four 32-bit channels: sdram, frame buffer, io, spare.
    localparam logic [31:0] SDRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] SDRAM_MASK = 32'hF000_0000;
    localparam logic [31:0] FB_BASE    = 32'h1000_0000;
    localparam logic [31:0] FB_MASK    = 32'hF000_0000;
    localparam logic [31:0] IO_BASE    = 32'h2000_0000;
    localparam logic [31:0] IO_MASK    = 32'hFFFF_0000;
    localparam logic [31:0] SPARE_BASE = 32'h3000_0000;
    localparam logic [31:0] SPARE_MASK = 32'hF000_0000;

    localparam logic [127:0] DEFAULT_REGION_BASE = {SPARE_BASE, IO_BASE, FB_BASE, SDRAM_BASE};
    localparam logic [127:0] DEFAULT_REGION_MASK = {SPARE_MASK, IO_MASK, FB_MASK, SDRAM_MASK};

    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_bus_region_decode.sv
// Combinational address decoder: one-hot hit vector plus any-hit flag.
// When regions overlap the lowest slave index wins.
module mem_bus_region_decode
    import mem_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit
);

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit &&
                ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
                hit[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// Data-bus decoder: one outstanding access from the core to NUM_SLAVES targets.
// Optional access timeout is enabled with the BUS_TIMEOUT_EN macro.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_req,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic                         m_write,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [1:0]                   m_size,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_done,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [ADDR_W-1:0]            s_addr,
    output logic                         s_write,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [1:0]                   s_size,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_bus_decoder: unsupported parameter set");
    end

    state_t                state;
    logic                  err_hold;
    logic [NUM_SLAVES-1:0] hit;
    logic                  any_hit;
    logic [ADDR_W-1:0]     sel_mask;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  sel_ready;

    mem_bus_region_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_region_decode (
        .addr    (m_addr),
        .hit     (hit),
        .any_hit (any_hit)
    );

    // Mask of the decoded region (for s_addr) and data/ready of the held selection.
    always_comb begin
        sel_mask  = '0;
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i]) begin
                sel_mask = sel_mask | REGION_MASK[i*ADDR_W +: ADDR_W];
            end
            if (s_sel[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
                sel_ready = sel_ready | s_ready[i];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] access_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            err_hold <= 1'b0;
            s_sel    <= '0;
            s_addr   <= '0;
            s_write  <= 1'b0;
            s_wdata  <= '0;
            s_size   <= '0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_rdata  <= '0;
`ifdef BUS_TIMEOUT_EN
            access_cnt <= '0;
`endif
        end else begin
            m_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_req) begin
                        if (any_hit && size_aligned(m_size, m_addr[1:0])) begin
                            s_sel   <= hit;
                            s_addr  <= m_addr & ~sel_mask;
                            s_write <= m_write;
                            s_wdata <= m_wdata;
                            s_size  <= m_size;
                            state   <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
                            access_cnt <= '0;
`endif
                        end else begin
                            // Hold RESP one extra cycle so a rejected request completes
                            // with the same latency as a zero-wait access.
                            m_err    <= 1'b1;
                            err_hold <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        s_sel  <= '0;
                        m_err  <= 1'b0;
                        m_done <= 1'b1;
                        if (!s_write) begin
                            m_rdata <= sel_rdata;
                        end
                        state <= ST_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        s_sel  <= '0;
                        m_err  <= 1'b1;
                        m_done <= 1'b1;
                        state  <= ST_RESP;
                    end else begin
                        access_cnt <= access_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (err_hold) begin
                        err_hold <= 1'b0;
                        m_done   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
